array_output_fifo: RTL and testbench

Parametrised collection FIFO behind the systolic array: gathers up to NUM_PORTS tagged results per cycle (value, row, col) from the array's output edge, compacts them in port order, and presents them one per cycle to the downstream writeback/requantisation stage. It adds ready/valid backpressure on both sides, configurable depth and data width, and sticky overflow reporting.

---
 rtl/array_out_pkg.sv | 21 ++
 rtl/valid_compactor.sv | 35 +++
 rtl/array_output_fifo.sv | 160 ++++++++++++++++
 tb/tb_array_output_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_out_pkg.sv
// Shared types for the systolic-array output path: result entry layout and
// width helpers used by the collection FIFO and the writeback stage.
package array_out_pkg;

   localparam int ENTRY_DATA_W = 32;
   localparam int ENTRY_MAX_N  = 16;
   localparam int ENTRY_N_BITS = $clog2(ENTRY_MAX_N);
   localparam int STAT_DROP_W  = 16;

   typedef struct packed {
      logic [ENTRY_DATA_W-1:0] data;
      logic [ENTRY_N_BITS-1:0] row;
      logic [ENTRY_N_BITS-1:0] col;
   } entry_t;

   // Width able to hold a lane count from 0 up to and including ports.
   function automatic int offset_width(input int ports);
      return $clog2(ports + 1);
   endfunction

endpackage

// File: rtl/valid_compactor.sv
// Exclusive prefix popcount over a sparse valid vector: each lane gets the
// number of valid lanes below it, plus the total number of valid lanes.
module valid_compactor
   import array_out_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int OFF_W     = offset_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0]            valid,
   output logic [NUM_PORTS-1:0][OFF_W-1:0] offset,
   output logic [OFF_W-1:0]                total
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_offset
         logic [OFF_W-1:0] acc;
         always_comb begin
            acc = '0;
            for (int j = 0; j < gi; j++) begin
               acc = acc + OFF_W'(valid[j]);
            end
         end
         assign offset[gi] = acc;
      end
   endgenerate

   always_comb begin
      total = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         total = total + OFF_W'(valid[j]);
      end
   end

endmodule

// File: rtl/array_output_fifo.sv
// Multi-port collection FIFO for systolic-array results: compacts up to
// NUM_PORTS tagged results per cycle and presents them show-ahead, one per cycle.
// Optional occupancy/drop statistics: define ARRAY_OUTPUT_FIFO_STATS_EN.
module array_output_fifo
   import array_out_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DEPTH     = 8,
   parameter int DATA_W    = ENTRY_DATA_W,
   parameter int MAX_N     = ENTRY_MAX_N,
   parameter int N_BITS    = $clog2(MAX_N),
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_PORTS-1:0]              in_valid,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]  in_data,
   input  logic [NUM_PORTS-1:0][N_BITS-1:0]  in_row,
   input  logic [NUM_PORTS-1:0][N_BITS-1:0]  in_col,
   output logic                              in_ready,
   output logic                              out_valid,
   output logic [DATA_W-1:0]                 out_data,
   output logic [N_BITS-1:0]                 out_row,
   output logic [N_BITS-1:0]                 out_col,
   input  logic                              out_ready,
   output logic [CNT_W-1:0]                  count,
   output logic                              overflow,
   input  logic                              overflow_clr
`ifdef ARRAY_OUTPUT_FIFO_STATS_EN
   ,
   output logic [CNT_W-1:0]                  hwm,
   output logic [STAT_DROP_W-1:0]            drop_cnt
`endif
);

   localparam int PTR_W     = $clog2(DEPTH);
   localparam int OFF_W     = offset_width(NUM_PORTS);
   localparam int READY_MAX = DEPTH - NUM_PORTS;

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [N_BITS-1:0] mem_row  [DEPTH];
   logic [N_BITS-1:0] mem_col  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             overflow_reg, overflow_next;

   logic [NUM_PORTS-1:0][OFF_W-1:0] wr_offset;
   logic [OFF_W-1:0]                wr_total;
   logic [NUM_PORTS-1:0][PTR_W-1:0] wr_addr;
   logic                            wr_accept;
   logic                            wr_drop;
   logic                            rd_fire;

   valid_compactor #(
      .NUM_PORTS(NUM_PORTS),
      .OFF_W    (OFF_W)
   ) u_compactor (
      .valid (in_valid),
      .offset(wr_offset),
      .total (wr_total)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_addr
         assign wr_addr[gi] = wr_ptr_reg + PTR_W'(wr_offset[gi]);
      end
   endgenerate

   // Readiness looks only at registered occupancy so upstream never sees a
   // combinational path from the consumer's out_ready.
   assign in_ready  = (count_reg <= CNT_W'(READY_MAX));
   assign out_valid = (count_reg != '0);
   assign wr_accept = in_ready && (|in_valid);
   assign wr_drop   = !in_ready && (|in_valid);
   assign rd_fire   = out_valid && out_ready;

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      if (wr_accept) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(wr_total);
      end
      if (rd_fire) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + (wr_accept ? CNT_W'(wr_total) : CNT_W'(0))
                   - CNT_W'(rd_fire);
      if (wr_drop) begin
         overflow_next = 1'b1;
      end else if (overflow_clr) begin
         overflow_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (wr_accept && in_valid[i]) begin
            mem_data[wr_addr[i]] <= in_data[i];
            mem_row[wr_addr[i]]  <= in_row[i];
            mem_col[wr_addr[i]]  <= in_col[i];
         end
      end
   end

   assign out_data = mem_data[rd_ptr_reg];
   assign out_row  = mem_row[rd_ptr_reg];
   assign out_col  = mem_col[rd_ptr_reg];
   assign count    = count_reg;
   assign overflow = overflow_reg;

`ifdef ARRAY_OUTPUT_FIFO_STATS_EN
   logic [CNT_W-1:0]       hwm_reg, hwm_next;
   logic [STAT_DROP_W-1:0] drop_cnt_reg, drop_cnt_next;

   always_comb begin
      hwm_next      = hwm_reg;
      drop_cnt_next = drop_cnt_reg;
      if (count_next > hwm_reg) begin
         hwm_next = count_next;
      end
      if (wr_drop && (drop_cnt_reg != '1)) begin
         drop_cnt_next = drop_cnt_reg + STAT_DROP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hwm_reg      <= '0;
         drop_cnt_reg <= '0;
      end else begin
         hwm_reg      <= hwm_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   assign hwm      = hwm_reg;
   assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_array_output_fifo.sv
// Self-checking bench for array_output_fifo against a queue-based reference
// model; stats outputs are checked when ARRAY_OUTPUT_FIFO_STATS_EN is defined.
module tb_array_output_fifo;

   localparam int NP    = 4;
   localparam int DEPTH = 8;
   localparam int DW    = 32;
   localparam int NB    = 4;
   localparam int CW    = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [NB-1:0] row;
      logic [NB-1:0] col;
   } ent_t;

   logic                     clk;
   logic                     reset;
   logic [NP-1:0]            in_valid;
   logic [NP-1:0][DW-1:0]    in_data;
   logic [NP-1:0][NB-1:0]    in_row;
   logic [NP-1:0][NB-1:0]    in_col;
   logic                     in_ready;
   logic                     out_valid;
   logic [DW-1:0]            out_data;
   logic [NB-1:0]            out_row;
   logic [NB-1:0]            out_col;
   logic                     out_ready;
   logic [CW-1:0]            count;
   logic                     overflow;
   logic                     overflow_clr;
`ifdef ARRAY_OUTPUT_FIFO_STATS_EN
   logic [CW-1:0]            hwm;
   logic [15:0]              drop_cnt;
`endif

   int   checks;
   int   failures;
   ent_t model_q[$];
   logic m_ovf;
   int   m_hwm;
   int   m_drops;

   array_output_fifo #(
      .NUM_PORTS(NP),
      .DEPTH    (DEPTH),
      .DATA_W   (DW),
      .MAX_N    (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_row      (in_row),
      .in_col      (in_col),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_ready   (out_ready),
      .count       (count),
      .overflow    (overflow),
      .overflow_clr(overflow_clr)
`ifdef ARRAY_OUTPUT_FIFO_STATS_EN
      ,
      .hwm         (hwm),
      .drop_cnt    (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit model_ready();
      return (DEPTH - model_q.size()) >= NP;
   endfunction

   task automatic model_clear();
      model_q.delete();
      m_ovf   = 1'b0;
      m_hwm   = 0;
      m_drops = 0;
   endtask

   // Applies one cycle of stimulus (called at a falling edge), advances the
   // model by the FIFO rules, and returns at the next falling edge.
   task automatic drive_cycle(input logic [NP-1:0] vld, input logic [NP-1:0][DW-1:0] d,
                              input logic ordy, input logic clr);
      logic [NP-1:0][NB-1:0] r;
      logic [NP-1:0][NB-1:0] c;
      bit rdy;
      bit do_rd;
      for (int i = 0; i < NP; i++) begin
         r[i] = NB'($urandom);
         c[i] = NB'($urandom);
      end
      in_valid     = vld;
      in_data      = d;
      in_row       = r;
      in_col       = c;
      out_ready    = ordy;
      overflow_clr = clr;
      rdy   = model_ready();
      do_rd = ordy && (model_q.size() > 0);
      if (vld != '0 && rdy) begin
         for (int i = 0; i < NP; i++) begin
            if (vld[i]) model_q.push_back('{data: d[i], row: r[i], col: c[i]});
         end
      end
      if (do_rd) void'(model_q.pop_front());
      if (vld != '0 && !rdy) begin
         m_ovf = 1'b1;
         if (m_drops < 65535) m_drops++;
      end else if (clr) begin
         m_ovf = 1'b0;
      end
      if (model_q.size() > m_hwm) m_hwm = model_q.size();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      in_valid = '0; in_data = '0; in_row = '0; in_col = '0;
      out_ready = 1'b0; overflow_clr = 1'b0;
      reset = 1'b0;
      #2;
      checks++; if (count !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      model_clear();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      $display("test_reset done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_full_group();
      logic [NP-1:0][DW-1:0] d;
      for (int i = 0; i < NP; i++) d[i] = DW'(10 + i);
      drive_cycle(4'b1111, d, 1'b0, 1'b0);
      checks++; if (count !== CW'(4)) begin failures++; $display("FAIL group_count got=%0d exp=4", count); end
      for (int k = 0; k < NP; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== DW'(10 + k)) begin
            failures++; $display("FAIL group_order k=%0d got_v=%b got=%0d exp=%0d", k, out_valid, out_data, 10 + k);
         end
         checks++;
         if ({out_row, out_col} !== {model_q[0].row, model_q[0].col}) begin
            failures++; $display("FAIL group_coord k=%0d got=%h exp=%h", k, {out_row, out_col}, {model_q[0].row, model_q[0].col});
         end
         drive_cycle('0, '0, 1'b1, 1'b0);
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL group_drained got=%b exp=0", out_valid); end
      $display("test_full_group done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_sparse();
      logic [NP-1:0][DW-1:0] d;
      for (int i = 0; i < NP; i++) d[i] = $urandom;
      d[1] = 21; d[3] = 23;
      drive_cycle(4'b1010, d, 1'b0, 1'b0);
      checks++; if (count !== CW'(2)) begin failures++; $display("FAIL sparse_count got=%0d exp=2", count); end
      checks++; if (out_data !== DW'(21)) begin failures++; $display("FAIL sparse_first got=%0d exp=21", out_data); end
      drive_cycle('0, '0, 1'b1, 1'b0);
      checks++; if (out_data !== DW'(23) || count !== CW'(1)) begin failures++; $display("FAIL sparse_second got=%0d cnt=%0d exp=23 cnt=1", out_data, count); end
      drive_cycle('0, '0, 1'b1, 1'b0);
      // Empty with write and read together: the read is ignored, entry appears next cycle.
      d[0] = 32'h5A5A_0001;
      drive_cycle(4'b0001, d, 1'b1, 1'b0);
      checks++;
      if (count !== CW'(1) || out_valid !== 1'b1 || out_data !== 32'h5A5A_0001) begin
         failures++; $display("FAIL no_bypass cnt=%0d v=%b data=%h exp cnt=1 v=1 data=5a5a0001", count, out_valid, out_data);
      end
      drive_cycle('0, '0, 1'b1, 1'b0);
      $display("test_sparse done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_overflow();
      logic [NP-1:0][DW-1:0] d;
      for (int i = 0; i < NP; i++) d[i] = $urandom;
      drive_cycle(4'b1111, d, 1'b0, 1'b0);
      drive_cycle(4'b0001, d, 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b0 || count !== CW'(5)) begin failures++; $display("FAIL ovf_fill rdy=%b cnt=%0d exp rdy=0 cnt=5", in_ready, count); end
      drive_cycle(4'b0001, d, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1 || count !== CW'(5)) begin failures++; $display("FAIL ovf_drop ovf=%b cnt=%0d exp ovf=1 cnt=5", overflow, count); end
      drive_cycle('0, '0, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
      drive_cycle(4'b0100, d, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
      drive_cycle('0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_data !== model_q[0].data) begin failures++; $display("FAIL ovf_drain k=%0d got=%h exp=%h", k, out_data, model_q[0].data); end
         drive_cycle('0, '0, 1'b1, 1'b0);
      end
      checks++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_end v=%b ovf=%b exp 0 0", out_valid, overflow); end
      $display("test_overflow done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_full_drop();
      logic [NP-1:0][DW-1:0] d;
      for (int i = 0; i < NP; i++) d[i] = $urandom;
      drive_cycle(4'b1111, d, 1'b0, 1'b0);
      drive_cycle(4'b1111, d, 1'b0, 1'b0);
      checks++; if (count !== CW'(8) || in_ready !== 1'b0) begin failures++; $display("FAIL full_fill cnt=%0d rdy=%b exp cnt=8 rdy=0", count, in_ready); end
      drive_cycle(4'b0001, d, 1'b1, 1'b0);
      checks++; if (count !== CW'(7) || overflow !== 1'b1) begin failures++; $display("FAIL full_rw cnt=%0d ovf=%b exp cnt=7 ovf=1", count, overflow); end
      while (model_q.size() > 0) begin
         checks++;
         if (out_data !== model_q[0].data) begin failures++; $display("FAIL full_drain got=%h exp=%h", out_data, model_q[0].data); end
         drive_cycle('0, '0, 1'b1, 1'b1);
      end
      $display("test_full_drop done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_back_to_back();
      logic [NP-1:0][DW-1:0] d;
      logic [NP-1:0] vld;
      for (int i = 0; i < NP; i++) d[i] = $urandom;
      drive_cycle(4'b1111, d, 1'b0, 1'b0);
      for (int cyc = 0; cyc < 40; cyc++) begin
         for (int i = 0; i < NP; i++) d[i] = $urandom;
         vld = model_ready() ? 4'b1111 : 4'b0000;
         drive_cycle(vld, d, 1'b1, 1'b0);
         checks++;
         if (count !== CW'(model_q.size()) || out_data !== model_q[0].data) begin
            failures++; $display("FAIL b2b cyc=%0d cnt=%0d exp=%0d data=%h exp=%h", cyc, count, model_q.size(), out_data, model_q[0].data);
         end
      end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_no_drop ovf=%b exp=0", overflow); end
      while (model_q.size() > 0) drive_cycle('0, '0, 1'b1, 1'b0);
      $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_random();
      logic [NP-1:0][DW-1:0] d;
      logic [NP-1:0] vld;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < NP; i++) d[i] = $urandom;
         vld = ($urandom_range(0, 2) == 0) ? 4'b0000 : NP'($urandom);
         drive_cycle(vld, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
         checks++;
         if (count !== CW'(model_q.size()) || out_valid !== (model_q.size() != 0)
             || in_ready !== model_ready() || overflow !== m_ovf) begin
            failures++;
            $display("FAIL rand_state cyc=%0d cnt=%0d/%0d v=%b rdy=%b/%b ovf=%b/%b", cyc, count, model_q.size(),
                     out_valid, in_ready, model_ready(), overflow, m_ovf);
         end
         if (model_q.size() > 0) begin
            checks++;
            if ({out_data, out_row, out_col} !== model_q[0]) begin
               failures++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, {out_data, out_row, out_col}, model_q[0]);
            end
         end
      end
`ifdef ARRAY_OUTPUT_FIFO_STATS_EN
      checks++;
      if (hwm !== CW'(m_hwm) || drop_cnt !== 16'(m_drops)) begin
         failures++; $display("FAIL rand_stats hwm=%0d/%0d drops=%0d/%0d", hwm, m_hwm, drop_cnt, m_drops);
      end
`endif
      $display("test_random done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_reset_mid();
      logic [NP-1:0][DW-1:0] d;
      while (model_q.size() > 0) drive_cycle('0, '0, 1'b1, 1'b1);
      drive_cycle('0, '0, 1'b0, 1'b1);
      for (int i = 0; i < NP; i++) d[i] = $urandom;
      drive_cycle(4'b1111, d, 1'b0, 1'b0);
      drive_cycle(4'b0011, d, 1'b0, 1'b0);
      checks++; if (count !== CW'(6)) begin failures++; $display("FAIL mid_pre cnt=%0d exp=6", count); end
      in_valid = '0;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== CW'(0) || in_ready !== 1'b1) begin
         failures++; $display("FAIL mid_reset v=%b cnt=%0d rdy=%b exp 0 0 1", out_valid, count, in_ready);
      end
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      d[2] = 32'h0000_ABCD;
      drive_cycle(4'b0100, d, 1'b0, 1'b0);
      checks++;
      if (count !== CW'(1) || out_data !== 32'h0000_ABCD || {out_row, out_col} !== {model_q[0].row, model_q[0].col}) begin
         failures++; $display("FAIL mid_after cnt=%0d data=%h exp cnt=1 data=0000abcd", count, out_data);
      end
      drive_cycle('0, '0, 1'b1, 1'b0);
      $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
   endtask

`ifdef ARRAY_OUTPUT_FIFO_STATS_EN
   task automatic test_stats();
      logic [NP-1:0][DW-1:0] d;
      reset = 1'b0;
      #2;
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NP; i++) d[i] = $urandom;
      drive_cycle(4'b1111, d, 1'b0, 1'b0);
      drive_cycle(4'b1111, d, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) drive_cycle(4'b0001, d, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) drive_cycle('0, '0, 1'b1, 1'b0);
      checks++; if (hwm !== CW'(8)) begin failures++; $display("FAIL stats_hwm got=%0d exp=8", hwm); end
      checks++; if (drop_cnt !== 16'd3) begin failures++; $display("FAIL stats_drops got=%0d exp=3", drop_cnt); end
      $display("test_stats done checks=%0d failures=%0d", checks, failures);
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_full_group();
      test_sparse();
      test_overflow();
      test_full_drop();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef ARRAY_OUTPUT_FIFO_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
